// File: rtl/meter_bcd_counter.sv
// Parking-meter remaining-time counter: 4-digit packed BCD with coin credit,
// preset loads and a 1 Hz countdown, saturating at 0000 and MAX_BCD.
module meter_bcd_counter #(
    parameter logic [15:0] INC0    = 16'h0050,
    parameter logic [15:0] INC1    = 16'h0150,
    parameter logic [15:0] INC2    = 16'h0200,
    parameter logic [15:0] INC3    = 16'h0500,
    parameter logic [15:0] LOAD0   = 16'h0010,
    parameter logic [15:0] LOAD1   = 16'h0205,
    parameter logic [15:0] MAX_BCD = 16'h9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1Hz,
    input  logic [3:0]  add_pulse,
    input  logic [1:0]  load_pulse,
    output logic [15:0] BCD_out,
    output logic        expired,
    output logic        add_busy
);

    typedef enum logic {IDLE, ADD_SUM} state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] inc_q, inc_d;
    logic        expired_q;

    // Digit-serial BCD add; a carry out of the thousands digit saturates.
    function automatic logic [15:0] bcdAddSat(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  digit;
        logic        carry;
        logic [15:0] sum;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < 4; i++) begin
            digit = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, carry};
            if (digit > 5'd9) begin
                digit = digit - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*i +: 4] = digit[3:0];
        end
        if (carry || (sum > MAX_BCD)) begin
            sum = MAX_BCD;
        end
        return sum;
    endfunction

    function automatic logic [15:0] bcdDecSat(input logic [15:0] a);
        logic [15:0] res;
        logic        borrow;
        res    = a;
        borrow = 1'b1;
        if (a != 16'h0000) begin
            for (int i = 0; i < 4; i++) begin
                if (borrow) begin
                    if (a[4*i +: 4] == 4'd0) begin
                        res[4*i +: 4] = 4'd9;
                    end else begin
                        res[4*i +: 4] = a[4*i +: 4] - 4'd1;
                        borrow        = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        inc_d   = inc_q;
        case (state_q)
            IDLE: begin
                if (load_pulse[1]) begin
                    count_d = LOAD1;
                end else if (load_pulse[0]) begin
                    count_d = LOAD0;
                end else begin
                    if (tick_1Hz) begin
                        count_d = bcdDecSat(count_q);
                    end
                    // Only the highest requested coin is credited.
                    if (add_pulse[3]) begin
                        inc_d   = INC3;
                        state_d = ADD_SUM;
                    end else if (add_pulse[2]) begin
                        inc_d   = INC2;
                        state_d = ADD_SUM;
                    end else if (add_pulse[1]) begin
                        inc_d   = INC1;
                        state_d = ADD_SUM;
                    end else if (add_pulse[0]) begin
                        inc_d   = INC0;
                        state_d = ADD_SUM;
                    end
                end
            end
            ADD_SUM: begin
                state_d = IDLE;
                if (load_pulse[1]) begin
                    count_d = LOAD1;
                end else if (load_pulse[0]) begin
                    count_d = LOAD0;
                end else begin
                    count_d = bcdAddSat(count_q, inc_q);
                    if (tick_1Hz) begin
                        count_d = bcdDecSat(count_d);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 16'h0000;
            inc_q     <= 16'h0000;
            expired_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            inc_q     <= inc_d;
            expired_q <= (count_d == 16'h0000);
        end
    end

    assign BCD_out  = count_q;
    assign expired  = expired_q;
    assign add_busy = (state_q == ADD_SUM);

endmodule

// File: tb/tb_meter_bcd_counter.sv
// Directed bench for meter_bcd_counter: one table row per clock cycle,
// plus looped sequences for the long countdown and the saturation climb.
module tb_meter_bcd_counter;

    logic        clk;
    logic        rst;
    logic        tick1Hz;
    logic [3:0]  addPulse;
    logic [1:0]  loadPulse;
    logic [15:0] bcdOut;
    logic        expiredOut;
    logic        addBusy;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        bit          rst;
        bit          tick;
        logic [3:0]  add;
        logic [1:0]  load;
        logic [15:0] expBcd;
        bit          expExpired;
        bit          expBusy;
        string       name;
    } vec_t;

    vec_t vecs[$];

    meter_bcd_counter dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1Hz   (tick1Hz),
        .add_pulse  (addPulse),
        .load_pulse (loadPulse),
        .BCD_out    (bcdOut),
        .expired    (expiredOut),
        .add_busy   (addBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic void addVec(input bit r, input bit t, input logic [3:0] a,
                                   input logic [1:0] l, input logic [15:0] b,
                                   input bit e, input bit busy, input string n);
        vec_t v;
        v.rst = r; v.tick = t; v.add = a; v.load = l;
        v.expBcd = b; v.expExpired = e; v.expBusy = busy; v.name = n;
        vecs.push_back(v);
    endfunction

    // Inputs are held for exactly one rising edge, then outputs are sampled 1 ns later.
    task automatic applyStimulus(input bit r, input bit t, input logic [3:0] a, input logic [1:0] l);
        rst       = r;
        tick1Hz   = t;
        addPulse  = a;
        loadPulse = l;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        tick1Hz   = 1'b0;
        addPulse  = 4'b0000;
        loadPulse = 2'b00;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expBcd,
                               input bit expExp, input bit expBusy);
        testsRun++;
        if (bcdOut !== expBcd || expiredOut !== expExp || addBusy !== expBusy) begin
            testsFailed++;
            $display("[TB] FAIL %s: got bcd=%h expired=%b busy=%b, expected bcd=%h expired=%b busy=%b",
                     name, bcdOut, expiredOut, addBusy, expBcd, expExp, expBusy);
        end
    endtask

    task automatic addCoin(input logic [3:0] a, input logic [15:0] expAfter);
        applyStimulus(1'b0, 1'b0, a, 2'b00);
        applyStimulus(1'b0, 1'b0, 4'b0000, 2'b00);
        checkOutput("coin", expAfter, expAfter == 16'h0000, 1'b0);
    endtask

    initial begin
        rst = 1'b0; tick1Hz = 1'b0; addPulse = 4'b0000; loadPulse = 2'b00;
        @(negedge clk);

        addVec(1, 0, 4'b0000, 2'b00, 16'h0000, 1, 0, "reset");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0000, 1, 0, "idle after reset");
        for (int i = 0; i < 5; i++) addVec(0, 1, 4'b0000, 2'b00, 16'h0000, 1, 0, "tick at zero");
        addVec(0, 0, 4'b0001, 2'b00, 16'h0000, 1, 1, "add0 busy");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0050, 0, 0, "add0 sum");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].tick, vecs[i].add, vecs[i].load);
            checkOutput(vecs[i].name, vecs[i].expBcd, vecs[i].expExpired, vecs[i].expBusy);
        end

        // Count 0050 down to 0000 and one tick beyond.
        for (int i = 1; i <= 51; i++) begin
            applyStimulus(1'b0, 1'b1, 4'b0000, 2'b00);
            checkOutput("countdown", toBcd((i > 50) ? 0 : 50 - i), i >= 50, 1'b0);
        end

        vecs.delete();
        addVec(0, 0, 4'b0000, 2'b10, 16'h0205, 0, 0, "load1");
        addVec(0, 1, 4'b0000, 2'b00, 16'h0204, 0, 0, "tick after load1");
        addVec(0, 0, 4'b0000, 2'b11, 16'h0205, 0, 0, "load1 over load0");
        addVec(0, 1, 4'b1000, 2'b01, 16'h0010, 0, 0, "load0 beats add+tick");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0010, 0, 0, "no add after load");
        addVec(0, 0, 4'b1001, 2'b00, 16'h0010, 0, 1, "multi-bit add busy");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0510, 0, 0, "highest bit only");
        addVec(1, 0, 4'b0000, 2'b00, 16'h0000, 1, 0, "reset 2");
        addVec(0, 0, 4'b0001, 2'b00, 16'h0000, 1, 1, "to 0100 a");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0050, 0, 0, "to 0100 b");
        addVec(0, 0, 4'b0001, 2'b00, 16'h0050, 0, 1, "to 0100 c");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0100, 0, 0, "to 0100 d");
        addVec(0, 1, 4'b0000, 2'b00, 16'h0099, 0, 0, "borrow 0100");
        addVec(1, 0, 4'b0000, 2'b00, 16'h0000, 1, 0, "reset 3");
        addVec(0, 0, 4'b1000, 2'b00, 16'h0000, 1, 1, "to 1000 a");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0500, 0, 0, "to 1000 b");
        addVec(0, 0, 4'b1000, 2'b00, 16'h0500, 0, 1, "to 1000 c");
        addVec(0, 0, 4'b0000, 2'b00, 16'h1000, 0, 0, "to 1000 d");
        addVec(0, 1, 4'b0000, 2'b00, 16'h0999, 0, 0, "borrow 1000");
        addVec(1, 0, 4'b0000, 2'b00, 16'h0000, 1, 0, "reset 4");
        addVec(0, 0, 4'b0001, 2'b00, 16'h0000, 1, 1, "to 0100 e");
        addVec(0, 0, 4'b0001, 2'b00, 16'h0050, 0, 0, "add ignored in ADD_SUM");
        addVec(0, 0, 4'b0001, 2'b00, 16'h0050, 0, 1, "to 0100 f");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0100, 0, 0, "to 0100 g");
        addVec(0, 1, 4'b0100, 2'b00, 16'h0099, 0, 1, "tick with add");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0299, 0, 0, "sum after tick");
        addVec(0, 0, 4'b0100, 2'b00, 16'h0299, 0, 1, "add before load");
        addVec(0, 1, 4'b0000, 2'b01, 16'h0010, 0, 0, "load0 in ADD_SUM");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0010, 0, 0, "add discarded");
        addVec(1, 0, 4'b0000, 2'b00, 16'h0000, 1, 0, "reset 5");
        addVec(0, 0, 4'b0010, 2'b00, 16'h0000, 1, 1, "to 0150 a");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0150, 0, 0, "to 0150 b");
        addVec(0, 0, 4'b0100, 2'b00, 16'h0150, 0, 1, "add before reset");
        addVec(1, 0, 4'b0000, 2'b00, 16'h0000, 1, 0, "reset in ADD_SUM");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0000, 1, 0, "no late add");
        addVec(0, 0, 4'b0010, 2'b00, 16'h0000, 1, 1, "to 0150 c");
        addVec(0, 0, 4'b0000, 2'b00, 16'h0150, 0, 0, "to 0150 d");
        addVec(0, 0, 4'b0001, 2'b00, 16'h0150, 0, 1, "add before tick");
        addVec(0, 1, 4'b0000, 2'b00, 16'h0199, 0, 0, "tick in ADD_SUM");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].tick, vecs[i].add, vecs[i].load);
            checkOutput(vecs[i].name, vecs[i].expBcd, vecs[i].expExpired, vecs[i].expBusy);
        end

        // Climb to 9800 with coins, then saturate at 9999.
        applyStimulus(1'b1, 1'b0, 4'b0000, 2'b00);
        checkOutput("reset 6", 16'h0000, 1'b1, 1'b0);
        for (int i = 1; i <= 19; i++) addCoin(4'b1000, toBcd(500 * i));
        addCoin(4'b0010, 16'h9650);
        addCoin(4'b0010, 16'h9800);
        addCoin(4'b1000, 16'h9999);
        addCoin(4'b0001, 16'h9999);
        applyStimulus(1'b0, 1'b1, 4'b0000, 2'b00);
        checkOutput("tick from max", 16'h9998, 1'b0, 1'b0);
        addCoin(4'b0100, 16'h9999);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
